// File: rtl/func_call_pkg.sv
// Shared defaults and the two-operand add call used by the operand pipe.
// The add is evaluated at a fixed maximum width; callers truncate to WIDTH+1 bits.
package func_call_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_DEPTH = 4;
   localparam int unsigned DEF_CNT_W = 16;
   localparam int unsigned ADD_W     = 64;

   // Zero-extended operands keep bit WIDTH of the truncated result equal to the carry.
   function automatic logic [ADD_W:0] add_call(input logic [ADD_W-1:0] a,
                                               input logic [ADD_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/func_operand_pipe_if.sv
// Operand/result handshake bundle for func_operand_pipe.
// The slave modport is the pipe itself; master is the producer/consumer side.
interface func_operand_pipe_if
   import func_call_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned CNT_W = DEF_CNT_W
);

   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          in_a;
   logic [WIDTH-1:0]          in_b;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          out_sum;
   logic                      out_carry;
   logic [CNT_W-1:0]          call_count;
   logic [$clog2(DEPTH):0]    fifo_level;

   modport slave (
      input  flush, in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_sum, out_carry, call_count, fifo_level
   );

   modport master (
      output flush, in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_sum, out_carry, call_count, fifo_level
   );

endinterface

// File: rtl/func_operand_fifo.sv
// Operand-pair FIFO with wrap-bit pointers; flush overrides push and pop.
// Push is judged against the registered full flag only, so a same-cycle pop never frees a slot.
module func_operand_fifo
   import func_call_pkg::*;
#(
   parameter  int unsigned DW    = 2 * DEF_WIDTH,
   parameter  int unsigned DEPTH = DEF_DEPTH,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push_req,
   input  logic          pop_req,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   logic [LW-1:0] wptr_q, wptr_d;
   logic [LW-1:0] rptr_q, rptr_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic          push;
   logic          pop;

   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty   = (wptr_q == rptr_q);
   assign level   = wptr_q - rptr_q;
   assign rd_data = mem_q[rptr_q[AW-1:0]];
   assign push    = push_req & ~full & ~flush;
   assign pop     = pop_req & ~empty & ~flush;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      mem_d  = mem_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push) begin
            mem_d[wptr_q[AW-1:0]] = wr_data;
            wptr_d                = wptr_q + LW'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + LW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/func_operand_pipe.sv
// Operand FIFO feeding a registered add call behind a valid/ready output,
// with a free-running count of delivered results.
module func_operand_pipe
   import func_call_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input logic                clk,
   input logic                rst_n,
   func_operand_pipe_if.slave bus
);

   logic [2*WIDTH-1:0] head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               fire;
   logic [WIDTH:0]     add_res;

   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_sum_q, out_sum_d;
   logic               out_carry_q, out_carry_d;
   logic [CNT_W-1:0]   call_count_q, call_count_d;

   func_operand_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush),
      .push_req (bus.in_valid),
      .pop_req  (pop),
      .wr_data  ({bus.in_a, bus.in_b}),
      .rd_data  (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (bus.fifo_level)
   );

   // A flush cycle neither pops nor counts a delivery.
   assign fire    = out_valid_q & bus.out_ready & ~bus.flush;
   assign pop     = ~fifo_empty & (~out_valid_q | bus.out_ready) & ~bus.flush;
   assign add_res = (WIDTH+1)'(add_call(ADD_W'(head[2*WIDTH-1:WIDTH]), ADD_W'(head[WIDTH-1:0])));

   always_comb begin
      out_valid_d  = out_valid_q;
      out_sum_d    = out_sum_q;
      out_carry_d  = out_carry_q;
      call_count_d = call_count_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else begin
         if (fire) begin
            call_count_d = call_count_q + CNT_W'(1);
         end
         if (pop) begin
            out_valid_d              = 1'b1;
            {out_carry_d, out_sum_d} = add_res;
         end else if (fire) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_sum_q    <= '0;
         out_carry_q  <= 1'b0;
         call_count_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_sum_q    <= out_sum_d;
         out_carry_q  <= out_carry_d;
         call_count_q <= call_count_d;
      end
   end

   assign bus.in_ready   = ~fifo_full;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_sum    = out_sum_q;
   assign bus.out_carry  = out_carry_q;
   assign bus.call_count = call_count_q;

endmodule
